// File: rtl/exe_mem_skid_if.sv
// Execute-to-memory handshake bundle: the upstream result channel from
// execute and the downstream result channel toward the memory stage.
interface exe_mem_skid_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // Upstream (execute -> buffer)
  logic          valid_i;
  logic          ready_o;
  logic [AW-1:0] reg_waddr_i;
  logic          reg_we_i;
  logic [DW-1:0] reg_wdata_i;
  // Downstream (buffer -> memory)
  logic          valid_o;
  logic          ready_i;
  logic [AW-1:0] reg_waddr_o;
  logic          reg_we_o;
  logic [DW-1:0] reg_wdata_o;

  // The pipeline register itself.
  modport slave (
    input  valid_i, reg_waddr_i, reg_we_i, reg_wdata_i, ready_i,
    output ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o
  );

  // The surrounding pipeline (execute producer and memory consumer).
  modport master (
    output valid_i, reg_waddr_i, reg_we_i, reg_wdata_i, ready_i,
    input  ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o
  );
endinterface

// File: rtl/exe_mem_skid.sv
// Execute/memory pipeline register built as a 2-entry skid buffer.
// The main entry drives the memory stage directly from registers; the skid
// entry catches one extra result when memory stalls so ready_o never depends
// combinationally on ready_i. Two lookup ports forward in-flight writes.
module exe_mem_skid #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  exe_mem_skid_if.slave bus,
  input  logic          flush_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          fwd1_hit_o,
  output logic [DW-1:0] fwd1_data_o,
  output logic          fwd2_hit_o,
  output logic [DW-1:0] fwd2_data_o,
  output logic [1:0]    count_o
);

  logic          r_main_valid;
  logic [AW-1:0] r_main_waddr;
  logic          r_main_we;
  logic [DW-1:0] r_main_wdata;
  logic          r_skid_valid;
  logic [AW-1:0] r_skid_waddr;
  logic          r_skid_we;
  logic [DW-1:0] r_skid_wdata;

  logic          w_main_valid;
  logic [AW-1:0] w_main_waddr;
  logic          w_main_we;
  logic [DW-1:0] w_main_wdata;
  logic          w_skid_valid;
  logic          w_skid_load;

  logic          w_accept;
  logic          w_drain;
  logic          w_in_we;

  // Writes to x0 are architecturally dead, so they are stored with we cleared.
  assign w_in_we  = bus.reg_we_i & (bus.reg_waddr_i != '0);
  assign w_accept = bus.valid_i & bus.ready_o & ~flush_i & ~rst_i;
  assign w_drain  = r_main_valid & bus.ready_i;

  // Next-state selection for both entries; main payload is zeroed whenever
  // main empties so the outputs read zero while valid_o is low.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_main_valid = r_main_valid;
    w_main_waddr = r_main_waddr;
    w_main_we    = r_main_we;
    w_main_wdata = r_main_wdata;
    w_skid_valid = r_skid_valid;
    w_skid_load  = 1'b0;

    if (flush_i) begin
      w_main_valid = 1'b0;
      w_main_waddr = '0;
      w_main_we    = 1'b0;
      w_main_wdata = '0;
      w_skid_valid = 1'b0;
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        // Skid is older than anything incoming: promote it.
        w_main_valid = 1'b1;
        w_main_waddr = r_skid_waddr;
        w_main_we    = r_skid_we;
        w_main_wdata = r_skid_wdata;
        w_skid_valid = 1'b0;
      end else if (w_accept) begin
        w_main_valid = 1'b1;
        w_main_waddr = bus.reg_waddr_i;
        w_main_we    = w_in_we;
        w_main_wdata = bus.reg_wdata_i;
      end else begin
        w_main_valid = 1'b0;
        w_main_waddr = '0;
        w_main_we    = 1'b0;
        w_main_wdata = '0;
      end
    end else if (w_accept) begin
      // Main is stalled: park the new result in the skid entry.
      w_skid_valid = 1'b1;
      w_skid_load  = 1'b1;
    end
  end

  // Valid bits and the output-facing main entry, cleared by reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_main_waddr <= '0;
      r_main_we    <= 1'b0;
      r_main_wdata <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid;
      r_main_waddr <= w_main_waddr;
      r_main_we    <= w_main_we;
      r_main_wdata <= w_main_wdata;
      r_skid_valid <= w_skid_valid;
    end
  end

  // Skid payload capture; qualified everywhere by r_skid_valid.
  always_ff @(posedge clk_i) begin
    // NOTE: payload registers guarded by a valid bit need no reset.
    if (w_skid_load) begin
      r_skid_waddr <= bus.reg_waddr_i;
      r_skid_we    <= w_in_we;
      r_skid_wdata <= bus.reg_wdata_i;
    end
  end

  assign bus.ready_o     = ~r_skid_valid;
  assign bus.valid_o     = r_main_valid;
  assign bus.reg_waddr_o = r_main_waddr;
  assign bus.reg_we_o    = r_main_we;
  assign bus.reg_wdata_o = r_main_wdata;
  assign count_o         = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  logic w_m1, w_s1, w_m2, w_s2;

  // Forwarding lookups; the skid entry is younger and wins on a double match.
  always_comb begin
    w_m1 = r_main_valid & r_main_we & (rs1_addr_i != '0) & (r_main_waddr == rs1_addr_i);
    w_s1 = r_skid_valid & r_skid_we & (rs1_addr_i != '0) & (r_skid_waddr == rs1_addr_i);
    w_m2 = r_main_valid & r_main_we & (rs2_addr_i != '0) & (r_main_waddr == rs2_addr_i);
    w_s2 = r_skid_valid & r_skid_we & (rs2_addr_i != '0) & (r_skid_waddr == rs2_addr_i);
    fwd1_hit_o  = w_m1 | w_s1;
    fwd1_data_o = w_s1 ? r_skid_wdata : (w_m1 ? r_main_wdata : '0);
    fwd2_hit_o  = w_m2 | w_s2;
    fwd2_data_o = w_s2 ? r_skid_wdata : (w_m2 ? r_main_wdata : '0);
  end

endmodule

// File: tb/tb_exe_mem_skid.sv
// Directed testbench for exe_mem_skid with an occupancy model and a
// FIFO scoreboard of expected output triples.
module tb_exe_mem_skid;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic          we;
    logic [DW-1:0] wdata;
  } entry_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i;
  logic          fwd1_hit_o, fwd2_hit_o;
  logic [DW-1:0] fwd1_data_o, fwd2_data_o;
  logic [1:0]    count_o;

  exe_mem_skid_if #(.AW(AW), .DW(DW)) bus ();

  exe_mem_skid #(.AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .flush_i     (flush_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .fwd1_hit_o  (fwd1_hit_o),
    .fwd1_data_o (fwd1_data_o),
    .fwd2_hit_o  (fwd2_hit_o),
    .fwd2_data_o (fwd2_data_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  int     n_vec = 0;
  int     n_err = 0;
  int     m_cnt = 0;
  entry_t sb[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    bus.valid_i     = v;
    bus.reg_waddr_i = a;
    bus.reg_we_i    = we;
    bus.reg_wdata_i = d;
  endtask

  // Check current outputs against the model, update the model for the
  // coming edge, then advance one clock and settle.
  task automatic cycle();
    logic   push, pop;
    entry_t e;
    chk("count", {30'd0, count_o}, m_cnt);
    chk("ready_o", bus.ready_o, (m_cnt != 2));
    chk("valid_o", bus.valid_o, (m_cnt != 0));
    if (m_cnt == 0) begin
      chk("idle_waddr", bus.reg_waddr_o, 0);
      chk("idle_we", bus.reg_we_o, 0);
      chk("idle_wdata", bus.reg_wdata_o, 0);
    end
    pop  = (m_cnt != 0) && bus.ready_i;
    push = bus.valid_i && (m_cnt != 2);
    if (rst_i || flush_i) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (pop) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_waddr", bus.reg_waddr_o, e.waddr);
          chk("out_we", bus.reg_we_o, e.we);
          chk("out_wdata", bus.reg_wdata_o, e.wdata);
        end
      end
      if (push) begin
        e.waddr = bus.reg_waddr_i;
        e.we    = bus.reg_we_i && (bus.reg_waddr_i != 0);
        e.wdata = bus.reg_wdata_i;
        sb.push_back(e);
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, bus.valid_o, 0);
    chk({tag, "_waddr"}, bus.reg_waddr_o, 0);
    chk({tag, "_we"}, bus.reg_we_o, 0);
    chk({tag, "_wdata"}, bus.reg_wdata_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_ready"}, bus.ready_o, 1);
    chk({tag, "_hit1"}, fwd1_hit_o, 0);
    chk({tag, "_hit2"}, fwd2_hit_o, 0);
    chk({tag, "_fd1"}, fwd1_data_o, 0);
    chk({tag, "_fd2"}, fwd2_data_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; bus.ready_i = 1'b1;
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd6;
    drive(1'b1, 5'd5, 1'b1, 32'h77);      // ignored under reset
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_values("reset");
    rst_i = 1'b0;
    drive(1'b0, 0, 0, 0);

    // Streaming at full rate.
    bus.ready_i = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 32'h11); cycle();
    drive(1'b1, 5'd6, 1'b1, 32'h22); cycle();
    drive(1'b1, 5'd7, 1'b1, 32'h33); cycle();
    drive(1'b0, 0, 0, 0); cycle(); cycle();

    // Streaming with a one-cycle ready_i drop.
    drive(1'b1, 5'd1, 1'b1, 32'h1001); cycle();
    bus.ready_i = 1'b0;
    drive(1'b1, 5'd2, 1'b1, 32'h1002); cycle();
    bus.ready_i = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h1003); cycle();
    drive(1'b1, 5'd4, 1'b0, 32'h1004); cycle();
    drive(1'b0, 0, 0, 0); cycle(); cycle(); cycle();

    // Backpressure: A then B held.
    bus.ready_i = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'hAA); cycle();
    drive(1'b1, 5'd4, 1'b1, 32'hBB); cycle();
    drive(1'b1, 5'd13, 1'b1, 32'hEE); cycle();   // refused: buffer full
    drive(1'b0, 0, 0, 0);
    chk("bp_hold_addr", bus.reg_waddr_o, 3);
    chk("bp_hold_data", bus.reg_wdata_o, 32'hAA);
    cycle();
    bus.ready_i = 1'b1;
    cycle(); cycle(); cycle();

    // Flush while full, with C presented in the same cycle.
    bus.ready_i = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 32'h1); cycle();
    drive(1'b1, 5'd11, 1'b1, 32'h2); cycle();
    flush_i = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 32'hCC); cycle();
    flush_i = 1'b0;
    drive(1'b0, 0, 0, 0);
    bus.ready_i = 1'b1;
    cycle(); cycle();

    // x0 normalisation.
    bus.ready_i = 1'b0;
    drive(1'b1, 5'd0, 1'b1, 32'hDEAD); cycle();
    drive(1'b0, 0, 0, 0);
    rs1_addr_i = 5'd0; #1;
    chk("x0_waddr", bus.reg_waddr_o, 0);
    chk("x0_we", bus.reg_we_o, 0);
    chk("x0_wdata", bus.reg_wdata_o, 32'hDEAD);
    chk("x0_fwd_hit", fwd1_hit_o, 0);
    chk("x0_fwd_data", fwd1_data_o, 0);
    bus.ready_i = 1'b1;
    cycle(); cycle();

    // Forward priority: skid beats main on the same register.
    bus.ready_i = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'h100); cycle();
    drive(1'b1, 5'd8, 1'b1, 32'h200); cycle();
    drive(1'b0, 0, 0, 0);
    rs1_addr_i = 5'd8; rs2_addr_i = 5'd2; #1;
    chk("fwd1_hit", fwd1_hit_o, 1);
    chk("fwd1_data", fwd1_data_o, 32'h200);
    chk("fwd2_hit", fwd2_hit_o, 0);
    chk("fwd2_data", fwd2_data_o, 0);
    cycle();

    // Reset mid-stall with both entries full.
    rst_i = 1'b1;
    drive(1'b1, 5'd14, 1'b1, 32'h99); cycle();
    rst_i = 1'b0;
    drive(1'b0, 0, 0, 0);
    chk_reset_values("rst_stall");
    bus.ready_i = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 32'h55); cycle();
    drive(1'b0, 0, 0, 0);
    chk("post_rst_valid", bus.valid_o, 1);
    chk("post_rst_data", bus.reg_wdata_o, 32'h55);
    cycle(); cycle();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/exe_mem_skid.md
# exe_mem_skid

Pipeline register between the execute stage and the memory stage, implemented as a 2-entry skid buffer with valid/ready handshaking. It captures the execute result (destination register, write enable, write data) and holds it stable while the memory stage stalls. It provides full-throughput flow when downstream is ready, supports a flush, and offers two combinational forwarding lookup ports so decode can bypass results still in flight.

## Interface
- AW, 5, register address width (matches `RADDR_WIDTH`)
- DW, 32, write-data width (matches `RDATA_WIDTH`)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  execute result valid this cycle
- ready_o  out  1  buffer can accept this cycle; equals !skid_valid (registered, no combinational path from ready_i)
- reg_waddr_i  in  AW  destination register from execute
- reg_we_i  in  1  write enable from execute
- reg_wdata_i  in  DW  write data from execute
- valid_o  out  1  output entry valid
- ready_i  in  1  memory stage accepts this cycle
- reg_waddr_o  out  AW  destination register to memory stage
- reg_we_o  out  1  write enable to memory stage
- reg_wdata_o  out  DW  write data to memory stage
- flush_i  in  1  discard all buffered and incoming entries
- rs1_addr_i, rs2_addr_i  in  AW each  forwarding lookup addresses
- fwd1_hit_o, fwd2_hit_o  out  1 each  lookup matched an in-flight write
- fwd1_data_o, fwd2_data_o  out  DW each  forwarded data (zero on miss)
- count_o  out  2  occupancy, 0..2

## Operation
- State: main entry (drives outputs) plus skid entry, each with a valid bit. Occupancy counts valid entries.
- accept = valid_i & ready_o & !flush_i & !rst_i. Drain = valid_o & ready_i.
- Write normalisation on capture: if reg_waddr_i == 0, the stored we is 0. Address and data are stored unchanged.
- Transitions, evaluated per cycle:
  - main empty, accept: the incoming result goes to main.
  - main full, drain, skid full: skid moves to main and skid empties. An accept in this case cannot occur, because ready_o is 0.
  - main full, drain, skid empty, accept: the incoming result goes to main.
  - main full, drain, skid empty, no accept: main empties.
  - main full, no drain, accept: the incoming result goes to skid, and ready_o is 0 from the next cycle.
  - main full, no drain, no accept: hold.
- Ordering: strict FIFO. The skid entry is always younger than main.
- Outputs when valid_o = 0: reg_waddr_o = 0, reg_we_o = 0, reg_wdata_o = 0.
- Outputs are stable while valid_o & !ready_i.
- Flush: both valid bits clear on the next edge. Any same-cycle valid_i is dropped, and drain is ignored. Flush has priority over everything except reset.
- Forwarding, per port n (combinational from stored state):
  - Hit if rsN_addr_i != 0 and a valid entry with we = 1 has a matching waddr.
  - When both entries match, the skid (younger) entry's data wins.
  - On a miss, hit = 0 and data = 0.

## Timing
- Reset (rst_i high at an edge): both valid bits are 0. Reset values:
  - valid_o = 0, reg_waddr_o = 0, reg_we_o = 0, reg_wdata_o = 0
  - count_o = 0, ready_o = 1
  - fwd1_hit_o = fwd2_hit_o = 0, fwd1_data_o = fwd2_data_o = 0
- While rst_i is high, inputs are ignored. Reset mid-stall discards both entries.
- Latency: an input accepted at edge N appears on the outputs after edge N, one cycle, when main was empty or draining.
- Throughput: 1 result/cycle with ready_i held high. After a one-cycle ready_i drop, no bubble and no loss.
- ready_o depends only on registered state.
- valid_o and the data outputs are registered.
- Forwarding outputs are combinational from registers and the rs addresses only.

## Test plan
- Streaming: ready_i = 1, push (x5, we 1, 0x11), (x6, we 1, 0x22), (x7, we 1, 0x33) on consecutive cycles. Required: the same triples appear on consecutive cycles one cycle later, and count_o stays 1.
- Backpressure: ready_i = 0, push A = (x3, 0xAA) then B = (x4, 0xBB). Required: after two edges count_o = 2, ready_o = 0, outputs hold A. Then raise ready_i: A drains, then B, then valid_o = 0.
- Flush while full: fill both entries, assert flush_i with valid_i = 1 and C = (x9, 0xCC). Required: next cycle valid_o = 0, count_o = 0, ready_o = 1, and C is never output.
- x0 normalisation: push (x0, we 1, 0xDEAD). Required: output waddr = 0, we = 0, data = 0xDEAD, and a forwarding lookup of rs1 = x0 gives hit = 0.
- Forward priority: main = (x8, we 1, 0x100), skid = (x8, we 1, 0x200), rs1 = x8, rs2 = x2. Required: fwd1_hit_o = 1 with data 0x200, and fwd2_hit_o = 0 with data 0.
- Reset mid-stall: both entries full, assert rst_i for one edge. Required: all outputs return to their reset values, ready_o = 1, and a push on the next cycle is output normally.
